granule_descaler_buffer: RTL and testbench
==========================================

// Module: granule_descaler_buffer
// PURPOSE
//  Consumer end of the requantizer output stream. Takes each (signed mantissa x, exponent magnitude base)
//  pair and turns it into one fixed-point sample, value = x * 2^(-base/4).
//  Collects 576 samples per granule into a ping-pong buffer and hands complete granules to the
//  downstream stage (reorder/stereo/IMDCT) through a random-access read port with a done handshake.
// PARAMETERS
//  OUT_W      32  width of stored/output sample, signed two's complement
//  FRAC_BITS  15  fractional bits of output sample; legal range 0..15
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset: synchronous, active-high
//  x_in         in   16      signed mantissa (two's complement) from requantizer x_out
//  x_base_in    in   10      unsigned exponent magnitude in quarter-steps; sample = x * 2^(-x_base_in/4)
//  din_v        in   1       sample valid; no backpressure exists upstream
//  sof          in   1       granule start pulse; resynchronises the write index to 0
//  rd_addr      in   10      read index 0..575 within the current read granule
//  rd_data      out  OUT_W   sample at rd_addr; 1-cycle read latency
//  gran_valid   out  1       read bank holds a complete granule
//  gran_done    in   1       consumer releases the read bank; ignored when gran_valid=0
//  overflow     out  1       sticky: a sample was dropped because both banks were full
// BEHAVIOUR
//  Reset values:
//   - rd_data=0, gran_valid=0, overflow=0.
//   - Write index=0, wr_bank=0, rd_bank=0, bank_full=2'b00, pipeline valids=0.
//   - A reset mid-granule discards all partial and full data.
//  Descale pipeline: 2 stages. A din_v at edge t is registered at t+1, then the result is written to RAM at t+2.
//   S1: k = base[1:0] selects C[k] (Q1.15, unsigned 17b) = {32768, 27554, 23170, 19484}.
//       prod = x_in * C[k] (signed, 34b); prod carries 15 fraction bits.
//   S2: s = base[9:2] + (15-FRAC_BITS).
//       If s == 0: r = prod.
//       Else: r = (prod + (1<<(s-1))) >>> s.
//       If s >= 34: r = 0.
//       Saturate r to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
//  Write side: one sample per valid result; the sample goes to RAM[wr_bank*576 + wr_idx].
//   - wr_idx increments on each write.
//   - When wr_idx==575 is written: bank_full[wr_bank] <= 1, wr_idx <= 0, wr_bank toggles.
//   - If bank_full[wr_bank]=1 when a result arrives: the sample is dropped, wr_idx is held, overflow <= 1.
//   - sof: wr_idx <= 0 and the partial granule is abandoned. This applies to samples entering S1 in the
//     same cycle and later; results already in flight still write at the old index sequence.
//   - An in-flight result colliding with the sof index reset writes first, then the index clears.
//  Read side:
//   - gran_valid = bank_full[rd_bank].
//   - rd_data <= RAM[rd_bank*576 + rd_addr] every cycle.
//   - rd_addr > 575 returns an undefined value and causes no state change.
//  Handshake: gran_done && gran_valid causes bank_full[rd_bank] <= 0 and rd_bank toggles.
//   gran_valid for the other bank is visible the next cycle.
//  Simultaneous events:
//   - gran_done and the 576th write on the other bank in the same cycle: both take effect.
//   - gran_done on a bank while a write targets that same bank cannot occur: the write side only targets
//     non-full banks.
//  gran_valid rises the cycle after the 576th write edge. Data at all 576 addresses is readable from then on.
// STRUCTURE
//  Shared package (mp3_pkg): GRANULE_LEN=576, QUARTER_POW2_Q15[4] table, and the sample typedef
//   logic signed [OUT_W-1:0].
//  Sub-module requant_descaler: S1/S2 arithmetic pipeline (x, base, v -> r, v), 2-cycle latency.
//  Storage: xilinx_simple_dual_port_ram, depth 1152, width OUT_W, LOW_LATENCY output mode
//   (1-cycle read, port B).
//  Top level holds the write index counter, bank_full/rd_bank/wr_bank state and the overflow flag.
// TESTING
//  1. x=1000, base=0 at index 0, then fill the granule -> rd_addr=0 gives 32768000; gran_valid=1 after the
//     576th sample.
//  2. x=-1000, base=2 -> stored -23170000. Also x=3, base=9 -> (82662+2)>>2 = 20666.
//  3. x=-7, base=200 (s>=34) -> 0. Also x=32767, base=0 with OUT_W=24 -> saturates to 8388607.
//  4. Back-to-back din_v for 1152 samples, no gran_done -> both banks full, overflow=0. Sample 1153 is
//     dropped and overflow=1 (sticky). gran_done -> bank 1 presented, and the next 576 samples go to bank 0.
//  5. sof asserted after 100 samples -> the next sample lands at index 0. gran_valid does not rise until
//     576 samples have been written after the sof.
//  6. rst asserted mid-granule with one bank full -> gran_valid=0, overflow=0, and the following granule is
//     written to bank 0 from index 0.

Source files
------------

// File: rtl/mp3_pkg.sv
// Shared constants for the granule path: granule length, quarter-step gain table
// and the default sample type.
package mp3_pkg;
    localparam int GRANULE_LEN = 576;
    localparam int RAM_DEPTH   = 2 * GRANULE_LEN;
    localparam int SAMPLE_W    = 32;

    // 2^(-k/4) for k = 0..3 in Q1.15
    localparam logic [16:0] QUARTER_POW2_Q15 [4] = '{17'd32768, 17'd27554, 17'd23170, 17'd19484};

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/requant_descaler.sv
// Two-stage descaler: S1 applies the fractional quarter-step gain, S2 applies the
// integer power-of-two shift with round-half-up and saturation to OUT_W.
module requant_descaler
    import mp3_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [15:0]      x,
    input  logic        [9:0]       base,
    input  logic                    v_in,
    output logic signed [OUT_W-1:0] r,
    output logic                    v_out
);
    localparam logic signed [35:0] MAX_V = 36'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [35:0] MIN_V = ~MAX_V;

    logic signed [33:0]      prod;
    logic        [7:0]       base_hi;
    logic                    v1;
    logic        [8:0]       s;
    logic signed [35:0]      shifted;
    logic signed [OUT_W-1:0] r_next;

    always_comb begin
        s       = 9'(base_hi) + 9'(15 - FRAC_BITS);
        shifted = '0;
        if (s == 9'd0)
            shifted = 36'(prod);
        else if (s < 9'd34)
            shifted = (36'(prod) + (36'sd1 <<< (s - 9'd1))) >>> s;

        if (shifted > MAX_V)
            r_next = MAX_V[OUT_W-1:0];
        else if (shifted < MIN_V)
            r_next = MIN_V[OUT_W-1:0];
        else
            r_next = shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            prod    <= '0;
            base_hi <= '0;
            v_out   <= 1'b0;
            r       <= '0;
        end else begin
            v1      <= v_in;
            prod    <= 34'(x) * 34'($signed({1'b0, QUARTER_POW2_Q15[base[1:0]]}));
            base_hi <= base[9:2];
            v_out   <= v1;
            r       <= r_next;
        end
    end
endmodule

// File: rtl/xilinx_simple_dual_port_ram.sv
// Simple dual-port RAM: port A write, port B registered read (1-cycle latency)
// with a resettable output register.
module xilinx_simple_dual_port_ram #(
    parameter int DEPTH  = 1152,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/granule_descaler_buffer.sv
// Descales the requantizer stream and collects 576-sample granules into a
// ping-pong buffer handed to the consumer with a valid/done handshake.
module granule_descaler_buffer
    import mp3_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [15:0]      x_in,
    input  logic        [9:0]       x_base_in,
    input  logic                    din_v,
    input  logic                    sof,
    input  logic        [9:0]       rd_addr,
    output logic        [OUT_W-1:0] rd_data,
    output logic                    gran_valid,
    input  logic                    gran_done,
    output logic                    overflow
);
    localparam int                ADDR_W     = $clog2(RAM_DEPTH);
    localparam logic [9:0]        LAST_IDX   = 10'(GRANULE_LEN - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(GRANULE_LEN);

    logic signed [OUT_W-1:0] res;
    logic                    res_v;
    logic [1:0]              sof_pipe;
    logic [9:0]              wr_idx;
    logic [9:0]              idx_eff;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0]              bank_full;
    logic [1:0]              bank_full_next;
    logic                    wr_en;
    logic                    wr_last;
    logic                    release_rd;
    logic [ADDR_W-1:0]       wr_addr;
    logic [ADDR_W-1:0]       ram_rd_addr;

    requant_descaler #(
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_descaler (
        .clk   (clk),
        .rst   (rst),
        .x     (x_in),
        .base  (x_base_in),
        .v_in  (din_v),
        .r     (res),
        .v_out (res_v)
    );

    // sof travels with the pipeline so in-flight results keep the old index sequence
    assign idx_eff     = sof_pipe[1] ? '0 : wr_idx;
    assign wr_en       = res_v && !bank_full[wr_bank];
    assign wr_last     = wr_en && (idx_eff == LAST_IDX);
    assign gran_valid  = bank_full[rd_bank];
    assign release_rd  = gran_done && gran_valid;
    assign wr_addr     = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(idx_eff);
    assign ram_rd_addr = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(rd_addr);

    always_comb begin
        bank_full_next = bank_full;
        if (wr_last)
            bank_full_next[wr_bank] = 1'b1;
        if (release_rd)
            bank_full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sof_pipe  <= '0;
            wr_idx    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            overflow  <= 1'b0;
        end else begin
            sof_pipe  <= {sof_pipe[0], sof};
            bank_full <= bank_full_next;
            if (release_rd)
                rd_bank <= ~rd_bank;
            if (res_v && bank_full[wr_bank])
                overflow <= 1'b1;
            if (wr_last) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else if (wr_en) begin
                wr_idx <= idx_eff + 10'd1;
            end else begin
                wr_idx <= idx_eff;
            end
        end
    end

    xilinx_simple_dual_port_ram #(
        .DEPTH  (RAM_DEPTH),
        .WIDTH  (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .wr_addr (wr_addr),
        .wr_data (res),
        .rd_addr (ram_rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_granule_descaler_buffer.sv
// Scoreboard bench: two widths of the buffer share stimulus; a reference model
// queues whole expected granules and a consumer monitor reads them back.
module tb_granule_descaler_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x_in = '0;
    logic [9:0]  x_base_in = '0;
    logic        din_v = 1'b0;
    logic        sof = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        gran_done = 1'b0;
    logic [31:0] rd_data;
    logic [23:0] rd_data_b;
    logic        gran_valid, gran_valid_b;
    logic        overflow, overflow_b;

    int total = 0;
    int bad = 0;
    int exp_a[$];
    int exp_b[$];
    int part_a[$];
    int part_b[$];
    bit busy = 1'b0;
    bit consumer_en = 1'b0;
    bit m_ovf = 1'b0;

    always #5 clk = ~clk;

    granule_descaler_buffer #(.OUT_W(32), .FRAC_BITS(15)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_base_in(x_base_in), .din_v(din_v), .sof(sof),
        .rd_addr(rd_addr), .rd_data(rd_data), .gran_valid(gran_valid), .gran_done(gran_done),
        .overflow(overflow)
    );

    granule_descaler_buffer #(.OUT_W(24), .FRAC_BITS(12)) dut_b (
        .clk(clk), .rst(rst), .x_in(x_in), .x_base_in(x_base_in), .din_v(din_v), .sof(sof),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .gran_valid(gran_valid_b), .gran_done(gran_done),
        .overflow(overflow_b)
    );

    // value = x * 2^(-base/4), rounded half-up, in OUT_W with FRAC_BITS fraction bits
    function automatic int model(input int x, input int base, input int outw, input int frac);
        int     c[4] = '{32768, 27554, 23170, 19484};
        longint prod = longint'(x) * longint'(c[base % 4]);
        int     s = base / 4 + 15 - frac;
        longint mx = (longint'(1) << (outw - 1)) - 1;
        longint r;
        if (s == 0)       r = prod;
        else if (s >= 34) r = 0;
        else              r = longint'($floor((real'(prod) + 2.0 ** (s - 1)) / (2.0 ** s)));
        if (r > mx)       r = mx;
        if (r < -mx - 1)  r = -mx - 1;
        return int'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input bit v, input int x, input int b, input bit s);
        @(negedge clk);
        din_v = v;
        x_in = 16'(x);
        x_base_in = 10'(b);
        sof = s;
        if (s) begin
            part_a.delete();
            part_b.delete();
        end
        if (v) begin
            if (exp_a.size() / 576 + (busy ? 1 : 0) >= 2) begin
                m_ovf = 1'b1;
            end else begin
                part_a.push_back(model(x, b, 32, 15));
                part_b.push_back(model(x, b, 24, 12));
                if (part_a.size() == 576) begin
                    exp_a = {exp_a, part_a};
                    exp_b = {exp_b, part_b};
                    part_a.delete();
                    part_b.delete();
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 0, 0, 1'b0);
    endtask

    function automatic int rx();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int rb();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 100));
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, rx(), rb(), 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n >= 5000) ? 1 : 0, 0);
    endtask

    task automatic check_flags(input string name, input bit gv);
        check({name, "_gv"}, gran_valid, gv);
        check({name, "_gv_b"}, gran_valid_b, gv);
        check({name, "_ovf"}, overflow, m_ovf);
        check({name, "_ovf_b"}, overflow_b, m_ovf);
    endtask

    // consumer monitor: reads a whole granule, compares, then releases it
    initial begin
        int ea, eb, first_bad, got_a, got_b;
        forever begin
            @(negedge clk);
            if (!rst && consumer_en && gran_valid) begin
                busy = 1'b1;
                first_bad = -1;
                got_a = 0; got_b = 0; ea = 0; eb = 0;
                total++;
                if (exp_a.size() < 576) begin
                    bad++;
                    $display("FAIL granule_unexpected: got gran_valid=1 expected no pending granule");
                end
                for (int a = 0; a <= 576; a++) begin
                    if (a > 0 && exp_a.size() > 0) begin
                        ea = exp_a.pop_front();
                        eb = exp_b.pop_front();
                        if (first_bad < 0 && (int'($signed(rd_data)) != ea || int'($signed(rd_data_b)) != eb)) begin
                            first_bad = a - 1;
                            got_a = int'($signed(rd_data));
                            got_b = int'($signed(rd_data_b));
                            bad++;
                            $display("FAIL granule_data idx %0d: got %0d/%0d expected %0d/%0d",
                                     first_bad, got_a, got_b, ea, eb);
                        end
                    end
                    if (a < 576) begin
                        rd_addr = 10'(a);
                        @(negedge clk);
                    end
                end
                gran_done = 1'b1;
                @(negedge clk);
                gran_done = 1'b0;
                busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dx[6] = '{1000, -1000, 3, -7, 32767, -32768};
        int db[6] = '{0, 2, 9, 200, 0, 3};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_data_b", rd_data_b, 0);
        check_flags("reset", 1'b0);

        // first granule: directed values up front, gran_valid timing on the 576th
        for (int i = 0; i < 6; i++) issue(1'b1, dx[i], db[i], 1'b0);
        fill(569);
        idle(3);
        check_flags("gran1_575", 1'b0);
        issue(1'b1, rx(), rb(), 1'b0);
        idle(2);
        check_flags("gran1_edge", 1'b0);
        idle(1);
        check_flags("gran1_full", 1'b1);
        consumer_en = 1'b1;
        drain();

        // random traffic with occasional sof, consumer running
        for (int i = 0; i < 2000; i++)
            issue($urandom_range(0, 9) < 7, rx(), rb(), $urandom_range(0, 599) == 0);
        idle(3);
        drain();

        // sof after 100 samples restarts the granule
        consumer_en = 1'b0;
        fill(100);
        issue(1'b1, rx(), rb(), 1'b1);
        fill(574);
        idle(5);
        check_flags("sof_575", 1'b0);
        issue(1'b1, rx(), rb(), 1'b0);
        idle(3);
        check_flags("sof_576", 1'b1);
        consumer_en = 1'b1;
        drain();

        // both banks full, then one dropped sample
        consumer_en = 1'b0;
        fill(1152);
        idle(3);
        check_flags("both_full", 1'b1);
        issue(1'b1, rx(), rb(), 1'b0);
        idle(3);
        check("drop_ovf_model", m_ovf, 1);
        check_flags("dropped", 1'b1);
        consumer_en = 1'b1;
        drain();
        fill(576);
        idle(3);
        drain();
        check_flags("ovf_sticky", 1'b0);

        // reset mid-granule with one bank full
        consumer_en = 1'b0;
        fill(676);
        idle(3);
        check_flags("pre_reset", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_a.delete(); exp_b.delete(); part_a.delete(); part_b.delete();
        m_ovf = 1'b0;
        check("post_reset_rd_data", rd_data, 0);
        check_flags("post_reset", 1'b0);
        consumer_en = 1'b1;
        fill(576);
        idle(3);
        drain();
        check_flags("final", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
